// File: rtl/puck_game_ctl_pkg.sv
// Shared definitions for the puck game-flow controller: state encoding,
// winner codes and default field/goal geometry.
package puck_game_ctl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_GOAL  = 3'd3,
    ST_OVER  = 3'd4
  } game_state_t;

  localparam logic [1:0] WINNER_NONE = 2'd0;
  localparam logic [1:0] WINNER_P1   = 2'd1;
  localparam logic [1:0] WINNER_P2   = 2'd2;

  // Goal-mouth geometry, also used by the field renderer.
  localparam int DEF_GOAL_LEFT_X  = 40;
  localparam int DEF_GOAL_RIGHT_X = 984;
  localparam int DEF_GOAL_Y_MIN   = 284;
  localparam int DEF_GOAL_Y_MAX   = 440;

endpackage

// File: rtl/puck_game_ctl_goal_detect.sv
// Combinational goal-mouth region test; the left goal wins if both regions
// ever overlap.
module puck_game_ctl_goal_detect
  import puck_game_ctl_pkg::*;
#(
  parameter int GOAL_LEFT_X  = DEF_GOAL_LEFT_X,
  parameter int GOAL_RIGHT_X = DEF_GOAL_RIGHT_X,
  parameter int GOAL_Y_MIN   = DEF_GOAL_Y_MIN,
  parameter int GOAL_Y_MAX   = DEF_GOAL_Y_MAX
) (
  input  logic [11:0] xpos_puck,
  input  logic [11:0] ypos_puck,
  output logic        goal_l,
  output logic        goal_r
);

  logic in_mouth_y;
  logic left_hit;
  logic right_hit;

  always_comb begin
    in_mouth_y = (ypos_puck >= 12'(GOAL_Y_MIN)) && (ypos_puck <= 12'(GOAL_Y_MAX));
    left_hit   = in_mouth_y && (xpos_puck <= 12'(GOAL_LEFT_X));
    right_hit  = in_mouth_y && (xpos_puck >= 12'(GOAL_RIGHT_X));
    goal_l     = left_hit;
    goal_r     = right_hit && !left_hit;
  end

endmodule

// File: rtl/puck_game_ctl.sv
// Game-flow controller for the air-hockey puck: serve / play / goal-freeze /
// game-over sequencing, goal scoring and puck centre/enable control.
module puck_game_ctl
  import puck_game_ctl_pkg::*;
#(
  parameter int GOAL_LEFT_X   = DEF_GOAL_LEFT_X,
  parameter int GOAL_RIGHT_X  = DEF_GOAL_RIGHT_X,
  parameter int GOAL_Y_MIN    = DEF_GOAL_Y_MIN,
  parameter int GOAL_Y_MAX    = DEF_GOAL_Y_MAX,
  parameter int SERVE_FRAMES  = 60,
  parameter int FREEZE_FRAMES = 90,
  parameter int WIN_SCORE     = 7
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        start,
  input  logic [11:0] xpos_puck,
  input  logic [11:0] ypos_puck,
  output logic        puck_center,
  output logic        puck_en,
  output logic [3:0]  score_p1,
  output logic [3:0]  score_p2,
  output logic [1:0]  winner,
  output logic [2:0]  game_state
);

  localparam logic [7:0] SERVE_LAST  = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] FREEZE_LAST = 8'(FREEZE_FRAMES - 1);
  localparam logic [3:0] WIN         = 4'(WIN_SCORE);

  game_state_t state;
  logic        start_q;
  logic        start_edge;
  logic [7:0]  frame_cnt;
  logic [7:0]  cnt_inc;
  logic        goal_l;
  logic        goal_r;

  puck_game_ctl_goal_detect #(
    .GOAL_LEFT_X  (GOAL_LEFT_X),
    .GOAL_RIGHT_X (GOAL_RIGHT_X),
    .GOAL_Y_MIN   (GOAL_Y_MIN),
    .GOAL_Y_MAX   (GOAL_Y_MAX)
  ) u_goal_detect (
    .xpos_puck (xpos_puck),
    .ypos_puck (ypos_puck),
    .goal_l    (goal_l),
    .goal_r    (goal_r)
  );

  assign start_edge = start && !start_q;
  assign cnt_inc    = (frame_cnt == '1) ? frame_cnt : frame_cnt + 8'd1;
  assign game_state = state;

  // puck_en follows the previous cycle's state, so it drops one cycle after
  // the goal is scored and rises one cycle after PLAY is entered.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state       <= ST_IDLE;
      start_q     <= 1'b1;
      frame_cnt   <= '0;
      score_p1    <= '0;
      score_p2    <= '0;
      winner      <= WINNER_NONE;
      puck_center <= 1'b0;
      puck_en     <= 1'b0;
    end else begin
      start_q     <= start;
      puck_center <= 1'b0;
      puck_en     <= (state == ST_PLAY);
      case (state)
        ST_IDLE, ST_OVER: begin
          if (start_edge) begin
            state       <= ST_SERVE;
            frame_cnt   <= '0;
            score_p1    <= '0;
            score_p2    <= '0;
            winner      <= WINNER_NONE;
            puck_center <= 1'b1;
          end
        end
        ST_SERVE: begin
          if (frame_tick) begin
            if (frame_cnt == SERVE_LAST) begin
              state     <= ST_PLAY;
              frame_cnt <= '0;
            end else begin
              frame_cnt <= cnt_inc;
            end
          end
        end
        ST_PLAY: begin
          if (frame_tick && goal_l) begin
            score_p2  <= score_p2 + 4'd1;
            state     <= ST_GOAL;
            frame_cnt <= '0;
          end else if (frame_tick && goal_r) begin
            score_p1  <= score_p1 + 4'd1;
            state     <= ST_GOAL;
            frame_cnt <= '0;
          end
        end
        ST_GOAL: begin
          if (score_p1 == WIN) begin
            winner <= WINNER_P1;
            state  <= ST_OVER;
          end else if (score_p2 == WIN) begin
            winner <= WINNER_P2;
            state  <= ST_OVER;
          end else if (frame_tick) begin
            if (frame_cnt == FREEZE_LAST) begin
              state       <= ST_SERVE;
              frame_cnt   <= '0;
              puck_center <= 1'b1;
            end else begin
              frame_cnt <= cnt_inc;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_puck_game_ctl.sv
// Self-checking bench for puck_game_ctl: phase-level reference model compared
// every cycle, plus literal expectations along a directed game script.
module tb_puck_game_ctl;

  localparam int CX = 512;
  localparam int CY = 362;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        start = 1'b0;
  logic [11:0] xpos_puck = 12'(CX);
  logic [11:0] ypos_puck = 12'(CY);
  logic        puck_center;
  logic        puck_en;
  logic [3:0]  score_p1;
  logic [3:0]  score_p2;
  logic [1:0]  winner;
  logic [2:0]  game_state;

  int n_checks = 0;
  int n_errors = 0;

  puck_game_ctl dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .start       (start),
    .xpos_puck   (xpos_puck),
    .ypos_puck   (ypos_puck),
    .puck_center (puck_center),
    .puck_en     (puck_en),
    .score_p1    (score_p1),
    .score_p2    (score_p2),
    .winner      (winner),
    .game_state  (game_state)
  );

  always #5 clk_in = !clk_in;

  // Reference model: phase 0 idle, 1 serve, 2 play, 3 goal freeze, 4 over.
  int m_phase = 0;
  int m_frames = 0;
  int m_s1 = 0;
  int m_s2 = 0;
  int m_win = 0;
  bit m_center = 0;
  bit m_en = 0;
  bit m_prev_start = 1;
  bit model_valid = 0;

  function automatic bit left_mouth(int x, int y);
    return (x <= 40) && (y inside {[284:440]});
  endfunction

  function automatic bit right_mouth(int x, int y);
    return (x >= 984) && (y inside {[284:440]});
  endfunction

  always @(posedge clk_in) begin
    bit rise;
    bit was_play;
    rise = start && !m_prev_start;
    was_play = (m_phase == 2);
    m_prev_start = start;
    m_center = 0;
    if (rst) begin
      model_valid = 1;
      m_phase = 0; m_frames = 0; m_s1 = 0; m_s2 = 0; m_win = 0;
      m_prev_start = 1;
      m_en = 0;
    end else begin
      m_en = was_play;
      if (m_phase == 0 || m_phase == 4) begin
        if (rise) begin
          m_phase = 1; m_frames = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_center = 1;
        end
      end else if (m_phase == 1) begin
        if (frame_tick) begin
          m_frames++;
          if (m_frames == 60) begin m_phase = 2; m_frames = 0; end
        end
      end else if (m_phase == 2) begin
        if (frame_tick && left_mouth(int'(xpos_puck), int'(ypos_puck))) begin
          m_s2++; m_phase = 3; m_frames = 0;
        end else if (frame_tick && right_mouth(int'(xpos_puck), int'(ypos_puck))) begin
          m_s1++; m_phase = 3; m_frames = 0;
        end
      end else if (m_phase == 3) begin
        if (m_s1 == 7) begin m_win = 1; m_phase = 4; end
        else if (m_s2 == 7) begin m_win = 2; m_phase = 4; end
        else if (frame_tick) begin
          m_frames++;
          if (m_frames == 90) begin m_phase = 1; m_frames = 0; m_center = 1; end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_in);
    if (model_valid) begin
      chk("model.game_state", int'(game_state), m_phase);
      chk("model.puck_center", int'(puck_center), int'(m_center));
      chk("model.puck_en", int'(puck_en), int'(m_en));
      chk("model.score_p1", int'(score_p1), m_s1);
      chk("model.score_p2", int'(score_p2), m_s2);
      chk("model.winner", int'(winner), m_win);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1; step();
      frame_tick = 1'b0; step(); step(); step();
    end
  endtask

  task automatic goal_at(input int x, input int y);
    xpos_puck = 12'(x); ypos_puck = 12'(y);
    frame_tick = 1'b1; step();
    frame_tick = 1'b0; xpos_puck = 12'(CX); ypos_puck = 12'(CY); step();
  endtask

  task automatic next_round();
    ticks(90);
    ticks(60);
    step(); step();
  endtask

  task automatic press_start();
    start = 1'b1; step();
  endtask

  initial begin
    step(); step(); step();
    chk("reset.game_state", int'(game_state), 0);
    chk("reset.puck_en", int'(puck_en), 0);
    rst = 1'b0;
    step();

    press_start();
    chk("start.puck_center", int'(puck_center), 1);
    chk("start.game_state", int'(game_state), 1);
    start = 1'b0; step();
    chk("start.center_once", int'(puck_center), 0);
    ticks(60);
    step();
    chk("serve.game_state", int'(game_state), 2);
    chk("serve.puck_en", int'(puck_en), 1);

    // goal condition without a frame tick must not score
    xpos_puck = 12'd30; ypos_puck = 12'd362;
    step(); step(); step();
    chk("notick.score_p2", int'(score_p2), 0);
    frame_tick = 1'b1; step();
    frame_tick = 1'b0; xpos_puck = 12'(CX); ypos_puck = 12'(CY);
    chk("goal_l.score_p2", int'(score_p2), 1);
    chk("goal_l.puck_en_hold", int'(puck_en), 1);
    chk("goal_l.game_state", int'(game_state), 3);
    step();
    chk("goal_l.puck_en_drop", int'(puck_en), 0);
    ticks(90);
    chk("freeze.game_state", int'(game_state), 1);
    ticks(60);
    step(); step();

    // right x but outside the mouth y range, then on the lower y bound
    xpos_puck = 12'd990; ypos_puck = 12'd100;
    ticks(3);
    chk("miss.score_p1", int'(score_p1), 0);
    chk("miss.game_state", int'(game_state), 2);
    goal_at(990, 284);
    chk("goal_r.score_p1", int'(score_p1), 1);
    next_round();
    goal_at(984, 440);
    next_round();
    goal_at(40, 284);
    next_round();
    goal_at(1023, 300);
    chk("mid.score_p1", int'(score_p1), 3);
    chk("mid.score_p2", int'(score_p2), 2);
    ticks(10);

    // reset in GOAL with start held high through the release
    rst = 1'b1; start = 1'b1; step();
    chk("rst.game_state", int'(game_state), 0);
    chk("rst.score_p1", int'(score_p1), 0);
    chk("rst.score_p2", int'(score_p2), 0);
    chk("rst.puck_en", int'(puck_en), 0);
    rst = 1'b0;
    step(); step(); step();
    chk("rst.start_held", int'(game_state), 0);
    start = 1'b0; step();
    press_start();
    chk("restart.game_state", int'(game_state), 1);
    start = 1'b0;
    ticks(60);
    step(); step();

    for (int g = 0; g < 7; g++) begin
      goal_at(984 + (g % 3) * 19, 284 + (g % 3) * 78);
      if (g < 6) next_round();
    end
    chk("over.game_state", int'(game_state), 4);
    chk("over.winner", int'(winner), 1);
    chk("over.score_p1", int'(score_p1), 7);
    step();
    chk("over.puck_en", int'(puck_en), 0);
    ticks(2);
    chk("over.hold", int'(game_state), 4);

    press_start();
    chk("newgame.game_state", int'(game_state), 1);
    chk("newgame.score_p1", int'(score_p1), 0);
    chk("newgame.winner", int'(winner), 0);
    chk("newgame.puck_center", int'(puck_center), 1);
    start = 1'b0;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/puck_game_ctl.md
Name: puck_game_ctl

Overview:
Game-flow controller for the air-hockey puck datapath. It sequences the puck motion block through serve, play, goal-freeze and game-over phases, detects goals from the puck position, keeps both players' scores and drives the puck re-centre and motion-enable controls. It sits between the frame-timing logic and the puck position controller. Its score and winner outputs feed the on-screen text/score renderer.

Parameters:
GOAL_LEFT_X, 40, puck x at or below this value (inside goal mouth) = goal for player 2
GOAL_RIGHT_X, 984, puck x at or above this value (inside goal mouth) = goal for player 1
GOAL_Y_MIN, 284, lower y bound of both goal mouths (inclusive)
GOAL_Y_MAX, 440, upper y bound of both goal mouths (inclusive)
SERVE_FRAMES, 60, frames the puck is held at centre before play starts
FREEZE_FRAMES, 90, frames the puck is held after a goal
WIN_SCORE, 7, score that ends the game (max 15)

Ports:
clk_in  in  1  system clock
rst  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle pulse per video frame
start  in  1  player start request, level; edge-detected internally
xpos_puck  in  12  current puck x (pixels)
ypos_puck  in  12  current puck y (pixels)
puck_center  out  1  one-cycle pulse: puck block reloads centre position
puck_en  out  1  puck motion/collision update enabled
score_p1  out  4  player 1 score
score_p2  out  4  player 2 score
winner  out  2  0 none, 1 player 1, 2 player 2
game_state  out  3  encoded FSM state, for the display block

Behaviour:
- All outputs registered. Reset values: puck_center=0, puck_en=0, scores=0, winner=0, state=IDLE (game_state=0).
- States (encoding): IDLE=0, SERVE=1, PLAY=2, GOAL=3, OVER=4.
- start is edge-detected with one flop (reset value 1, so a start held high through reset is not a new edge). A rising edge is recognised one cycle after start goes high.
- IDLE: on start edge -> SERVE. Scores cleared, puck_center pulsed in the same cycle the transition registers.
- SERVE: frame counter cleared on entry and incremented on each frame_tick. When the count reaches SERVE_FRAMES -> PLAY.
- PLAY: puck_en=1. Goal evaluated only on cycles with frame_tick=1.
  - Left goal test: x <= GOAL_LEFT_X and GOAL_Y_MIN <= y <= GOAL_Y_MAX. Increments score_p2.
  - Right goal test: x >= GOAL_RIGHT_X and y in the same range. Increments score_p1.
  - Left test has priority if both are true (only possible with bad parameters).
  - On a goal: score increments in the same cycle, puck_en drops the next cycle, -> GOAL.
  - Start edges are ignored in PLAY.
- GOAL: puck_en=0. Frame counter cleared on entry.
  - If the new score equals WIN_SCORE -> OVER immediately (next cycle), and winner is set.
  - Otherwise, after FREEZE_FRAMES ticks, pulse puck_center and -> SERVE.
- OVER: puck_en=0, scores and winner held. Start edge -> clear scores and winner, pulse puck_center, -> SERVE.
- Arithmetic:
  - Frame counter is 8 bits and saturates.
  - Score comparison is 4-bit unsigned; scores never exceed WIN_SCORE.
  - Position compares are 12-bit unsigned; no subtraction is used, so there is no wrap-around hazard.
- frame_tick coincident with a state transition is consumed by the old state only and is not counted in the new state.
- rst asserted mid-game returns to IDLE in one cycle from any state. The puck block resets separately on the same rst.
- Latency: goal frame_tick -> score visible 1 cycle; puck_en low at 2 cycles.

Decomposition:
- Shared package: state encoding constants, winner codes, the default field/goal geometry constants (also used by the field renderer).
- One natural sub-module: goal_detect. It is combinational and holds the two region compares plus priority, giving 2 outputs (goal_l, goal_r).
- FSM, counters and scores stay in the top.

Test Plan:
- Reset then start pulse -> puck_center high for exactly 1 cycle, state=SERVE. After 60 frame_ticks, state=PLAY and puck_en=1.
- PLAY, puck (30,362) on a frame_tick -> score_p2=1 next cycle, puck_en=0 the cycle after. After 90 ticks, puck_center pulse and state=SERVE.
- PLAY, puck (990,100) (outside goal mouth y range) -> no score change, remains PLAY. Puck (990,284) on a tick -> score_p1 increments.
- Drive player 1 to 7 goals -> state=OVER, winner=1, puck_en=0. A start edge clears scores and gives SERVE.
- Goal condition present on a non-tick cycle -> no score change until the next frame_tick.
- rst asserted in GOAL with score 3:2 -> next cycle IDLE, scores 0, puck_en 0. start held high across the reset release -> no transition until start falls and rises again.
